// File: rtl/tx_payload_buffer.sv
// Store-and-forward TX payload byte FIFO with committed-packet counting.
// Define TX_BUF_PKT_DROP_EN to drop a whole packet when one of its bytes is rejected.
module tx_payload_buffer #(
  parameter int DEPTH    = 2048,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int MAX_PKTS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic [7:0]        ff_out_data_in,
  output logic [1:0]        bf_out_buffer_ready,
  input  logic              bf_in_r_en,
  input  logic              bf_in_pct_txed,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic              underflow
);

  typedef logic [ADDR_W:0] ptr_t;

  logic [7:0] mem_q [DEPTH];

  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       cm_ptr_q, cm_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  logic [1:0] pkt_cnt_q, pkt_cnt_d;
  logic       txed_q;
  logic [7:0] head_q, head_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
`ifdef TX_BUF_PKT_DROP_EN
  logic       drop_q, drop_d;
`endif

  logic full, slot_ok, space_ok;
  logic wr_fire, commit, pop, txed_rise, dec;

  always_comb begin
    full     = (wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH);
    slot_ok  = pkt_cnt_q < 2'(MAX_PKTS);
    space_ok = !full && slot_ok;
`ifdef TX_BUF_PKT_DROP_EN
    wr_ready = drop_q || space_ok;
`else
    wr_ready = space_ok;
`endif
  end

  always_comb begin
    wr_fire  = 1'b0;
    commit   = 1'b0;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
`ifdef TX_BUF_PKT_DROP_EN
    drop_d = drop_q;
    if (wr_en && drop_q) begin
      // swallow the rest of a rejected packet
      drop_d = !wr_last;
    end else if (wr_en && space_ok) begin
      wr_fire = 1'b1;
      commit  = wr_last;
    end else if (wr_en) begin
      drop_d = !wr_last;
    end
    if (wr_en && !drop_q && !space_ok) begin
      wr_ptr_d = cm_ptr_q;
    end else if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (commit) cm_ptr_d = wr_ptr_q + 1'b1;
`else
    if (wr_en && space_ok) begin
      wr_fire  = 1'b1;
      commit   = wr_last;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_last) cm_ptr_d = wr_ptr_q + 1'b1;
    end else if (wr_en && wr_last && slot_ok
                 && wr_ptr_q != cm_ptr_q) begin
      // rejected last byte still closes the truncated packet
      commit   = 1'b1;
      cm_ptr_d = wr_ptr_q;
    end
`endif
  end

  always_comb begin
    pop       = bf_in_r_en && (rd_ptr_q != cm_ptr_q);
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    txed_rise = bf_in_pct_txed && !txed_q;
    dec       = txed_rise && (pkt_cnt_q != 2'd0);
    pkt_cnt_d = pkt_cnt_q;
    if (commit && !dec) pkt_cnt_d = pkt_cnt_q + 2'd1;
    if (!commit && dec) pkt_cnt_d = pkt_cnt_q - 2'd1;
    ovf_d = ovf_q || (wr_en && !wr_ready);
    unf_d = unf_q || (bf_in_r_en && !pop)
          || (txed_rise && pkt_cnt_q == 2'd0);
    head_d = head_q;
    if (rd_ptr_d != cm_ptr_d) begin
      // bypass a byte written and committed this cycle
      if (wr_fire && rd_ptr_d == wr_ptr_q)
        head_d = wr_data;
      else
        head_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pkt_cnt_q <= '0;
      txed_q    <= 1'b0;
      head_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
`ifdef TX_BUF_PKT_DROP_EN
      drop_q    <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      txed_q    <= bf_in_pct_txed;
      head_q    <= head_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
`ifdef TX_BUF_PKT_DROP_EN
      drop_q    <= drop_d;
`endif
    end
  end

  assign ff_out_data_in      = head_q;
  assign bf_out_buffer_ready = pkt_cnt_q;
  assign fill_level          = wr_ptr_q - rd_ptr_q;
  assign overflow            = ovf_q;
  assign underflow           = unf_q;

endmodule
